avg_run_ctrl: RTL and testbench

Run controller that sequences the running-average counter and the averaging accumulator. It turns asynchronous start/stop buttons into clean one-cycle events and frames incoming samples into windows of `WINDOW`. It emits one count-enable pulse per completed average, which drives the counter's `en` input. It sits between the board buttons and the sample source on one side, and the counter and accumulator on the other.

---
 rtl/avg_run_ctrl_pkg.sv | 18 +
 rtl/avg_run_ctrl_btn_edge.sv | 32 +++
 rtl/avg_run_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_avg_run_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_run_ctrl_pkg.sv
// Shared definitions for the running-average run controller.
// Holds the FSM state encoding and the default framing/timeout parameters.
package avg_run_ctrl_pkg;

    // Fixed 3-bit encodings so state values stay stable for debug probes.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StArm  = 3'd1,
        StRun  = 3'd2,
        StDump = 3'd3,
        StHalt = 3'd4
    } state_e;

    localparam int unsigned DefaultWindow  = 8;
    localparam int unsigned DefaultTimeout = 1_000_000;
    localparam int unsigned DefaultToW     = 20;

endpackage

// File: rtl/avg_run_ctrl_btn_edge.sv
// Button conditioner: 2-flop synchronizer followed by a registered
// rising-edge detector. A held button gives a single one-cycle event,
// three cycles after the raw input rises.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   raw - asynchronous button level
//   ev  - one-cycle event pulse
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic ev
);

    // [0],[1] are the synchronizer stages, [2] is the previous synced level.
    logic [2:0] sync_q;
    logic       ev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            ev_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], raw};
            ev_q   <= sync_q[1] & ~sync_q[2];
        end
    end

    assign ev = ev_q;

endmodule

// File: rtl/avg_run_ctrl.sv
// Run controller for the running-average datapath. Conditions the start and
// stop buttons, frames samples into windows of WINDOW and sequences the
// accumulator clear/dump and the counter enable/clear pulses.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   start, stop   - raw asynchronous buttons
//   sample_valid  - one strobe per delivered sample
//   acc_clr       - accumulator clear pulse (ARM)
//   acc_dump      - accumulator latch/divide pulse (DUMP)
//   cnt_en        - counter enable pulse, one per completed window
//   cnt_clr       - counter clear pulse (ARM)
//   running       - high in RUN and DUMP
//   timed_out     - sticky, set when a run aborts for lack of samples
//   win_idx       - sample index within the current window
module avg_run_ctrl
    import avg_run_ctrl_pkg::*;
#(
    parameter int unsigned WINDOW  = DefaultWindow,
    parameter int unsigned TIMEOUT = DefaultTimeout,
    parameter int unsigned TO_W    = DefaultToW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       sample_valid,
    output logic       acc_clr,
    output logic       acc_dump,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       running,
    output logic       timed_out,
    output logic [3:0] win_idx
);

    localparam logic [3:0]      WinLast = 4'(WINDOW - 1);
    localparam logic [TO_W-1:0] ToLast  = TO_W'(TIMEOUT - 1);

    logic start_ev;
    logic stop_ev;

    state_e          state_q, state_d;
    logic [3:0]      win_q, win_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            tmo_q, tmo_d;

    logic acc_clr_q, acc_clr_d;
    logic acc_dump_q, acc_dump_d;
    logic cnt_en_q, cnt_en_d;
    logic cnt_clr_q, cnt_clr_d;
    logic running_q, running_d;

    btn_edge u_start_edge (
        .clk (clk),
        .rst (rst),
        .raw (start),
        .ev  (start_ev)
    );

    btn_edge u_stop_edge (
        .clk (clk),
        .rst (rst),
        .raw (stop),
        .ev  (stop_ev)
    );

    // State, window index, timeout counter and sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            win_q   <= '0;
            to_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            to_q    <= to_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        to_d    = to_q;
        tmo_d   = tmo_q;
        case (state_q)
            StIdle: begin
                if (start_ev) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                state_d = StRun;
            end
            StRun: begin
                if (stop_ev) begin
                    state_d = StHalt;
                end else if (!sample_valid && (to_q == ToLast)) begin
                    state_d = StHalt;
                    tmo_d   = 1'b1;
                end else if (sample_valid) begin
                    to_d = '0;
                    if (win_q == WinLast) begin
                        state_d = StDump;
                        win_d   = '0;
                    end else begin
                        win_d = win_q + 4'd1;
                    end
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            StDump: begin
                if (sample_valid) begin
                    to_d = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
                if (stop_ev) begin
                    state_d = StHalt;
                end else begin
                    state_d = StRun;
                    // Sample taken during the dump opens the next window.
                    if (sample_valid) begin
                        win_d = 4'd1;
                    end
                end
            end
            StHalt: begin
                if (start_ev) begin
                    state_d = StArm;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Entering ARM starts a fresh run.
        if (state_d == StArm) begin
            win_d = '0;
            to_d  = '0;
            tmo_d = 1'b0;
        end
    end

    // Outputs are decoded from the next state so the registered pulses line
    // up with the ARM/DUMP state cycle.
    always_comb begin
        acc_clr_d  = (state_d == StArm);
        cnt_clr_d  = (state_d == StArm);
        acc_dump_d = (state_d == StDump);
        cnt_en_d   = (state_d == StDump);
        running_d  = (state_d == StRun) || (state_d == StDump);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_clr_q  <= 1'b0;
            acc_dump_q <= 1'b0;
            cnt_en_q   <= 1'b0;
            cnt_clr_q  <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            acc_clr_q  <= acc_clr_d;
            acc_dump_q <= acc_dump_d;
            cnt_en_q   <= cnt_en_d;
            cnt_clr_q  <= cnt_clr_d;
            running_q  <= running_d;
        end
    end

    assign acc_clr   = acc_clr_q;
    assign acc_dump  = acc_dump_q;
    assign cnt_en    = cnt_en_q;
    assign cnt_clr   = cnt_clr_q;
    assign running   = running_q;
    assign timed_out = tmo_q;
    assign win_idx   = win_q;

endmodule

// File: tb/tb_avg_run_ctrl.sv
// Self-checking bench for avg_run_ctrl: directed scenarios followed by a
// randomized phase, every cycle compared against a behavioural model.
module tb_avg_run_ctrl;

    localparam int WIN = 8;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       sample_valid;
    logic       acc_clr;
    logic       acc_dump;
    logic       cnt_en;
    logic       cnt_clr;
    logic       running;
    logic       timed_out;
    logic [3:0] win_idx;

    avg_run_ctrl #(
        .WINDOW  (WIN),
        .TIMEOUT (TMO),
        .TO_W    (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .sample_valid (sample_valid),
        .acc_clr      (acc_clr),
        .acc_dump     (acc_dump),
        .cnt_en       (cnt_en),
        .cnt_clr      (cnt_clr),
        .running      (running),
        .timed_out    (timed_out),
        .win_idx      (win_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase of the run, samples seen in the window,
    // cycles since the last sample, and raw button history.
    localparam int PIdle = 0, PArm = 1, PRun = 2, PDump = 3, PHalt = 4;
    int   m_phase;
    int   m_samples;
    int   m_quiet;
    bit   m_tmo;
    bit   hist_start [$];
    bit   hist_stop  [$];

    int   tick_no = 0;
    int   n_cnt_en, n_acc_clr, n_cnt_clr;
    int   pulse_ticks [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Button event seen by the controller at this edge: raw rose 3 edges ago.
    function automatic bit button_event(input bit h [$]);
        return h[2] && !h[3];
    endfunction

    task automatic model_edge();
        bit sev, pev;
        if (rst) begin
            m_phase   = PIdle;
            m_samples = 0;
            m_quiet   = 0;
            m_tmo     = 1'b0;
            hist_start = '{0, 0, 0, 0};
            hist_stop  = '{0, 0, 0, 0};
            return;
        end
        sev = button_event(hist_start);
        pev = button_event(hist_stop);
        hist_start.push_front(start);
        hist_start.pop_back();
        hist_stop.push_front(stop);
        hist_stop.pop_back();
        case (m_phase)
            PIdle, PHalt: if (sev) m_phase = PArm;
            PArm: m_phase = PRun;
            PRun: begin
                if (pev) m_phase = PHalt;
                else if (!sample_valid && m_quiet == TMO - 1) begin
                    m_phase = PHalt;
                    m_tmo   = 1'b1;
                end else if (sample_valid) begin
                    m_quiet   = 0;
                    m_samples = m_samples + 1;
                    if (m_samples == WIN) begin
                        m_samples = 0;
                        m_phase   = PDump;
                    end
                end else m_quiet++;
            end
            PDump: begin
                m_quiet = sample_valid ? 0 : m_quiet + 1;
                if (pev) m_phase = PHalt;
                else begin
                    m_phase = PRun;
                    if (sample_valid) m_samples = 1;
                end
            end
            default: m_phase = PIdle;
        endcase
        if (m_phase == PArm) begin
            m_samples = 0;
            m_quiet   = 0;
            m_tmo     = 1'b0;
        end
    endtask

    task automatic tick();
        logic [9:0] exp_v, obs_v;
        model_edge();
        @(posedge clk);
        #1;
        tick_no++;
        exp_v = {m_phase == PArm, m_phase == PDump, m_phase == PDump, m_phase == PArm,
                 (m_phase == PRun) || (m_phase == PDump), m_tmo, 4'(m_samples)};
        obs_v = {acc_clr, acc_dump, cnt_en, cnt_clr, running, timed_out, win_idx};
        chk("cycle_model", 32'(obs_v), 32'(exp_v));
        if (cnt_en === 1'b1) begin
            n_cnt_en++;
            pulse_ticks.push_back(tick_no);
        end
        if (acc_clr === 1'b1) n_acc_clr++;
        if (cnt_clr === 1'b1) n_cnt_clr++;
    endtask

    task automatic clear_counts();
        n_cnt_en  = 0;
        n_acc_clr = 0;
        n_cnt_clr = 0;
        pulse_ticks.delete();
    endtask

    // Start button pulse; leaves the controller in RUN (ARM after 4 edges).
    task automatic press_start_to_run();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("arm_cnt_clr", 32'(cnt_clr), 32'd1);
        chk("arm_win_idx", 32'(win_idx), 32'd0);
        tick();
        chk("arm_to_run", 32'(running), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        sample_valid = 1'b0;
        clear_counts();
        tick();
        tick();
        chk("reset_outputs", 32'({acc_clr, acc_dump, cnt_en, cnt_clr, running, timed_out,
                                  win_idx}), 32'd0);
        rst = 1'b0;
        tick();

        // Single window.
        clear_counts();
        press_start_to_run();
        sample_valid = 1'b1;
        repeat (WIN - 1) tick();
        chk("win_no_early_en", 32'(cnt_en), 32'd0);
        tick();
        sample_valid = 1'b0;
        chk("win_cnt_en", 32'(cnt_en), 32'd1);
        chk("win_acc_dump", 32'(acc_dump), 32'd1);
        chk("win_idx_zero", 32'(win_idx), 32'd0);
        tick();
        chk("win_en_one_cycle", 32'(cnt_en), 32'd0);
        chk("win_acc_clr_once", 32'(n_acc_clr), 32'd1);
        chk("win_cnt_clr_once", 32'(n_cnt_clr), 32'd1);
        chk("win_cnt_en_once", 32'(n_cnt_en), 32'd1);

        // Back-to-back windows.
        clear_counts();
        sample_valid = 1'b1;
        repeat (3 * WIN) tick();
        sample_valid = 1'b0;
        chk("b2b_pulses", 32'(n_cnt_en), 32'd3);
        if (pulse_ticks.size() == 3) begin
            chk("b2b_gap1", 32'(pulse_ticks[1] - pulse_ticks[0]), 32'(WIN));
            chk("b2b_gap2", 32'(pulse_ticks[2] - pulse_ticks[1]), 32'(WIN));
        end
        tick();

        // Stop mid-window.
        clear_counts();
        sample_valid = 1'b1;
        repeat (5) tick();
        sample_valid = 1'b0;
        chk("mid_win_idx", 32'(win_idx), 32'd5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
        chk("stop_running", 32'(running), 32'd0);
        chk("stop_win_hold", 32'(win_idx), 32'd5);
        chk("stop_no_en", 32'(n_cnt_en), 32'd0);
        press_start_to_run();

        // Simultaneous start and stop in RUN.
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        repeat (3) tick();
        chk("simul_halt", 32'(running), 32'd0);
        press_start_to_run();

        // Stop event lands on the DUMP cycle.
        clear_counts();
        sample_valid = 1'b1;
        repeat (5) tick();
        stop = 1'b1;
        repeat (3) tick();
        sample_valid = 1'b0;
        chk("dump_stop_en", 32'(cnt_en), 32'd1);
        stop = 1'b0;
        tick();
        chk("dump_stop_halt", 32'(running), 32'd0);
        chk("dump_stop_en_once", 32'(n_cnt_en), 32'd1);

        // Timeout.
        press_start_to_run();
        sample_valid = 1'b1;
        repeat (3) tick();
        sample_valid = 1'b0;
        repeat (TMO - 1) tick();
        chk("to_still_run", 32'(running), 32'd1);
        tick();
        chk("to_halt", 32'(running), 32'd0);
        chk("to_flag", 32'(timed_out), 32'd1);
        press_start_to_run();
        chk("to_flag_clear", 32'(timed_out), 32'd0);

        // Reset mid-run, then a long button hold.
        sample_valid = 1'b1;
        repeat (6) tick();
        sample_valid = 1'b0;
        chk("rst_pre_idx", 32'(win_idx), 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_outputs", 32'({acc_clr, acc_dump, cnt_en, cnt_clr, running, timed_out,
                                    win_idx}), 32'd0);
        clear_counts();
        start = 1'b1;
        repeat (100) tick();
        start = 1'b0;
        chk("hold_one_arm", 32'(n_acc_clr), 32'd1);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            sample_valid = ($urandom % 4) != 0;
            if ($urandom % 24 == 0) start = ~start;
            if ($urandom % 60 == 0) stop = ~stop;
            rst = ($urandom % 500) == 0;
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        sample_valid = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
